i2c_slave_readback_tx: RTL and testbench

//  I2C slave-transmitter (read direction) on the shared SCL/SDA bus from the Arduino master.
//  On a read to SLAVE_ADDR it returns the SDRAM readback word, MSB byte first.
//  TX_DATA is driven by sdram_loader's READ_DATA, letting the Arduino verify loaded contents.

---
 rtl/i2c_slave_readback_tx_if.sv | 22 ++
 rtl/i2c_slave_readback_tx.sv | 193 +++++++++++++++++++
 tb/tb_i2c_slave_readback_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_readback_tx_if.sv
// Word handshake between the SDRAM loader (master side) and the I2C readback transmitter (slave side).
// TX_DATA/TX_VALID flow toward the transmitter; the status pulses and BUSY flow back.
interface i2c_slave_readback_tx_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] TX_DATA;
    logic                    TX_VALID;
    logic                    TX_ACCEPT;
    logic                    TX_DONE;
    logic                    TX_ABORT;
    logic                    BUSY;

    modport master (
        output TX_DATA, TX_VALID,
        input  TX_ACCEPT, TX_DONE, TX_ABORT, BUSY
    );

    modport slave (
        input  TX_DATA, TX_VALID,
        output TX_ACCEPT, TX_DONE, TX_ABORT, BUSY
    );
endinterface

// File: rtl/i2c_slave_readback_tx.sv
// I2C slave transmitter: answers reads to SLAVE_ADDR with one latched word, MSB byte first,
// oversampling SCL/SDA from the system clock and driving SDA open-drain.
module i2c_slave_readback_tx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic                  MAX10_CLK1_50,
    input  logic                  RESET_N,
    input  logic                  SCL,
    inout  wire                   SDA,
    i2c_slave_readback_tx_if.slave tx_if
);
    localparam int W   = 8 * WORD_BYTES;
    localparam int BCW = $clog2(WORD_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(WORD_BYTES);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_TX_BYTE   = 3'd3;
    localparam logic [2:0] ST_WAIT_MACK = 3'd4;
    localparam logic [2:0] ST_WAIT_STOP = 3'd5;

    logic [1:0]     scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic           scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]     state_q, state_d;
    logic [7:0]     addr_sr_q, addr_sr_d;
    logic [3:0]     addr_cnt_q, addr_cnt_d;
    logic [W-1:0]   word_q, word_d;
    logic [7:0]     cur_byte_q, cur_byte_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic           mack_q, mack_d;
    logic           word_active_q, word_active_d;
    logic           sda_oe_q, sda_oe_d;
    logic           accept_q, accept_d, done_q, done_d, abort_q, abort_d;

    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic       load_byte;
    logic [7:0] next_byte;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // Bus conditions need SCL high on both samples so an SCL edge is never mistaken for one.
    assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;
    assign next_byte = (byte_cnt_q < LAST_BYTE) ? word_q[W-1 -: 8] : FILL_BYTE;

    always_comb begin
        scl_sync_d    = {scl_sync_q[0], SCL};
        sda_sync_d    = {sda_sync_q[0], SDA};
        scl_prev_d    = scl_s;
        sda_prev_d    = sda_s;
        state_d       = state_q;
        addr_sr_d     = addr_sr_q;
        addr_cnt_d    = addr_cnt_q;
        word_d        = word_q;
        cur_byte_d    = cur_byte_q;
        bit_idx_d     = bit_idx_q;
        byte_cnt_d    = byte_cnt_q;
        mack_d        = mack_q;
        word_active_d = word_active_q;
        sda_oe_d      = sda_oe_q;
        accept_d      = 1'b0;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        load_byte     = 1'b0;

        if (start_det || stop_det) begin
            state_d    = start_det ? ST_ADDR : ST_IDLE;
            sda_oe_d   = 1'b0;
            addr_cnt_d = 4'd0;
            if (word_active_q) begin
                abort_d       = 1'b1;
                word_active_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise && addr_cnt_q < 4'd8) begin
                        addr_sr_d  = {addr_sr_q[6:0], sda_s};
                        addr_cnt_d = addr_cnt_q + 4'd1;
                    end else if (scl_fall && addr_cnt_q == 4'd8) begin
                        if (addr_sr_q[7:1] == SLAVE_ADDR && addr_sr_q[0] && tx_if.TX_VALID) begin
                            sda_oe_d      = 1'b1;
                            accept_d      = 1'b1;
                            word_d        = tx_if.TX_DATA;
                            byte_cnt_d    = '0;
                            word_active_d = 1'b1;
                            state_d       = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: load_byte = scl_fall;
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_idx_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_MACK;
                            if (byte_cnt_q != LAST_BYTE) byte_cnt_d = byte_cnt_q + BCW'(1);
                        end else begin
                            bit_idx_d = bit_idx_q - 3'd1;
                            sda_oe_d  = ~cur_byte_q[bit_idx_q - 3'd1];
                        end
                    end
                end
                ST_WAIT_MACK: begin
                    if (scl_rise) begin
                        mack_d = sda_s;
                        if (word_active_q && byte_cnt_q == LAST_BYTE) begin
                            done_d        = 1'b1;
                            word_active_d = 1'b0;
                        end
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            load_byte = 1'b1;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            if (word_active_q) begin
                                abort_d       = 1'b1;
                                word_active_d = 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT_STOP: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // Once the word is used up next_byte yields FILL_BYTE and the shifted-in zeros are ignored.
        if (load_byte) begin
            cur_byte_d = next_byte;
            word_d     = word_q << 8;
            bit_idx_d  = 3'd7;
            sda_oe_d   = ~next_byte[7];
            state_d    = ST_TX_BYTE;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync_q    <= 2'b11;
            sda_sync_q    <= 2'b11;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            state_q       <= ST_IDLE;
            addr_sr_q     <= '0;
            addr_cnt_q    <= '0;
            word_q        <= '0;
            cur_byte_q    <= '0;
            bit_idx_q     <= '0;
            byte_cnt_q    <= '0;
            mack_q        <= 1'b0;
            word_active_q <= 1'b0;
            sda_oe_q      <= 1'b0;
            accept_q      <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            scl_sync_q    <= scl_sync_d;
            sda_sync_q    <= sda_sync_d;
            scl_prev_q    <= scl_prev_d;
            sda_prev_q    <= sda_prev_d;
            state_q       <= state_d;
            addr_sr_q     <= addr_sr_d;
            addr_cnt_q    <= addr_cnt_d;
            word_q        <= word_d;
            cur_byte_q    <= cur_byte_d;
            bit_idx_q     <= bit_idx_d;
            byte_cnt_q    <= byte_cnt_d;
            mack_q        <= mack_d;
            word_active_q <= word_active_d;
            sda_oe_q      <= sda_oe_d;
            accept_q      <= accept_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
        end
    end

    assign SDA             = sda_oe_q ? 1'b0 : 1'bz;
    assign tx_if.TX_ACCEPT = accept_q;
    assign tx_if.TX_DONE   = done_q;
    assign tx_if.TX_ABORT  = abort_q;
    assign tx_if.BUSY      = (state_q == ST_ADDR_ACK) || (state_q == ST_TX_BYTE) ||
                             (state_q == ST_WAIT_MACK);
endmodule

// File: tb/tb_i2c_slave_readback_tx.sv
// Directed bench for i2c_slave_readback_tx: a bit-banged I2C master reads the word back
// and the status pulses are tallied for each transaction.
module tb_i2c_slave_readback_tx;
    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic m_sda_low;
    wire  SDA;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_done   = 0;
    int n_abort  = 0;
    int n_slv_low = 0;

    i2c_slave_readback_tx_if #(.WORD_BYTES(4)) tx_if ();

    i2c_slave_readback_tx #(
        .SLAVE_ADDR(7'h42),
        .WORD_BYTES(4),
        .FILL_BYTE (8'hFF)
    ) dut (
        .MAX10_CLK1_50(clk),
        .RESET_N      (rst_n),
        .SCL          (scl),
        .SDA          (SDA),
        .tx_if        (tx_if)
    );

    pullup (SDA);
    assign SDA = m_sda_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (tx_if.TX_ACCEPT) n_acc <= n_acc + 1;
        if (tx_if.TX_DONE)   n_done <= n_done + 1;
        if (tx_if.TX_ABORT)  n_abort <= n_abort + 1;
        if (SDA === 1'b0 && !m_sda_low) n_slv_low <= n_slv_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; #200;
        scl = 1'b1;       #200;
        m_sda_low = 1'b1; #200;
        scl = 1'b0;       #200;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #100;
        scl = 1'b1;       #200;
        m_sda_low = 1'b0; #200;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; #100;
            scl = 1'b1;        #200;
            scl = 1'b0;        #100;
        end
        m_sda_low = 1'b0; #100;
        scl = 1'b1;       #100;
        ack = SDA;        #100;
        scl = 1'b0;       #100;
    endtask

    task automatic recv_bit(output logic v);
        #200;
        scl = 1'b1; #100;
        v = SDA;    #100;
        scl = 1'b0;
    endtask

    task automatic recv_byte(input logic give_ack, output logic [7:0] b);
        logic v;
        m_sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(v);
            b[i] = v;
        end
        #100;
        m_sda_low = give_ack; #100;
        scl = 1'b1;           #200;
        scl = 1'b0;           #100;
        m_sda_low = 1'b0;
    endtask

    initial begin
        logic       ack, v;
        logic [7:0] b;
        logic [3:0] nib;
        int acc0, done0, abort0, low0;

        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0;
        tx_if.TX_DATA = 32'hDEADBEEF; tx_if.TX_VALID = 1'b1;
        #103;
        chk("rst_accept", tx_if.TX_ACCEPT, 0);
        chk("rst_done",   tx_if.TX_DONE, 0);
        chk("rst_abort",  tx_if.TX_ABORT, 0);
        chk("rst_busy",   tx_if.BUSY, 0);
        chk("rst_sda",    SDA, 1);
        rst_n = 1'b1; #200;

        // Read full word, NACK last byte; TX_DATA changed after accept must not leak in.
        acc0 = n_acc; done0 = n_done; abort0 = n_abort;
        bus_start();
        send_byte(8'h85, ack);
        chk("t1_addr_ack", ack, 0);
        chk("t1_busy", tx_if.BUSY, 1);
        tx_if.TX_DATA = 32'h0;
        recv_byte(1'b1, b); chk("t1_byte0", b, 8'hDE);
        recv_byte(1'b1, b); chk("t1_byte1", b, 8'hAD);
        recv_byte(1'b1, b); chk("t1_byte2", b, 8'hBE);
        recv_byte(1'b0, b); chk("t1_byte3", b, 8'hEF);
        bus_stop(); #200;
        chk("t1_accepts", n_acc - acc0, 1);
        chk("t1_dones",   n_done - done0, 1);
        chk("t1_aborts",  n_abort - abort0, 0);
        chk("t1_busy_end", tx_if.BUSY, 0);

        // Write to us and read to another address: silence.
        tx_if.TX_DATA = 32'hDEADBEEF;
        acc0 = n_acc; done0 = n_done; abort0 = n_abort; low0 = n_slv_low;
        bus_start(); send_byte(8'h84, ack); chk("t2_write_nack", ack, 1); bus_stop(); #200;
        bus_start(); send_byte(8'h87, ack); chk("t2_other_nack", ack, 1); bus_stop(); #200;
        chk("t2_sda_driven", n_slv_low - low0, 0);
        chk("t2_pulses", (n_acc - acc0) + (n_done - done0) + (n_abort - abort0), 0);
        chk("t2_busy", tx_if.BUSY, 0);

        // TX_VALID low at address time.
        tx_if.TX_VALID = 1'b0;
        acc0 = n_acc;
        bus_start(); send_byte(8'h85, ack); chk("t3_addr_nack", ack, 1); bus_stop(); #200;
        chk("t3_accepts", n_acc - acc0, 0);
        tx_if.TX_VALID = 1'b1;

        // Master NACKs after the second byte.
        acc0 = n_acc; done0 = n_done; abort0 = n_abort;
        bus_start(); send_byte(8'h85, ack); chk("t4_addr_ack", ack, 0);
        recv_byte(1'b1, b); chk("t4_byte0", b, 8'hDE);
        recv_byte(1'b0, b); chk("t4_byte1", b, 8'hAD);
        #100;
        chk("t4_busy_waitstop", tx_if.BUSY, 0);
        chk("t4_sda_released", SDA, 1);
        bus_stop(); #200;
        chk("t4_aborts", n_abort - abort0, 1);
        chk("t4_dones",  n_done - done0, 0);

        // Five ACKed bytes: fill byte after the word.
        acc0 = n_acc; done0 = n_done; abort0 = n_abort;
        bus_start(); send_byte(8'h85, ack); chk("t5_addr_ack", ack, 0);
        recv_byte(1'b1, b); recv_byte(1'b1, b); recv_byte(1'b1, b);
        recv_byte(1'b1, b); chk("t5_byte3", b, 8'hEF);
        chk("t5_done_at_byte3", n_done - done0, 1);
        recv_byte(1'b1, b); chk("t5_fill", b, 8'hFF);
        bus_stop(); #200;
        chk("t5_dones",  n_done - done0, 1);
        chk("t5_aborts", n_abort - abort0, 0);

        // Repeated START in the middle of the second byte, then re-address.
        acc0 = n_acc; done0 = n_done; abort0 = n_abort;
        bus_start(); send_byte(8'h85, ack); chk("t6r_addr_ack", ack, 0);
        recv_byte(1'b1, b); chk("t6r_byte0", b, 8'hDE);
        recv_bit(v); chk("t6r_b7", v, 1);
        recv_bit(v); chk("t6r_b6", v, 0);
        bus_start(); #100;
        chk("t6r_abort", n_abort - abort0, 1);
        send_byte(8'h85, ack); chk("t6r_readdr_ack", ack, 0);
        recv_byte(1'b0, b); chk("t6r_readdr_byte0", b, 8'hDE);
        bus_stop(); #200;
        chk("t6r_accepts", n_acc - acc0, 2);
        chk("t6r_dones", n_done - done0, 0);

        // Reset while the slave drives bit 3 (a zero) of the first byte.
        tx_if.TX_DATA = 32'h12345678;
        bus_start(); send_byte(8'h85, ack); chk("t6_addr_ack", ack, 0);
        m_sda_low = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            recv_bit(v);
            nib[i] = v;
        end
        chk("t6_high_nibble", nib, 4'h1);
        #200;
        chk("t6_sda_driven", SDA, 0);
        rst_n = 1'b0; #1;
        chk("t6_sda_rel", SDA, 1);
        chk("t6_rst_busy", tx_if.BUSY, 0);
        chk("t6_rst_pulses", {tx_if.TX_ACCEPT, tx_if.TX_DONE, tx_if.TX_ABORT}, 0);
        #100; rst_n = 1'b1; #200;
        acc0 = n_acc;
        bus_start(); send_byte(8'h85, ack); chk("t6_after_rst_ack", ack, 0);
        recv_byte(1'b0, b); chk("t6_after_rst_byte0", b, 8'h12);
        bus_stop(); #200;
        chk("t6_after_rst_accepts", n_acc - acc0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
